// File: rtl/reg_seq_pkg.sv
// Shared constants for the REG micro-sequencer: widths, opcodes, FSM states and
// instruction field positions.
package reg_seq_pkg;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int IW = 3 + 2 * AW + DW;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    // rb aliases the low AW bits of the immediate field.
    localparam int IMM_LSB = 0;
    localparam int RB_LSB  = 0;
    localparam int RA_LSB  = DW;
    localparam int RD_LSB  = DW + AW;
    localparam int OP_LSB  = DW + 2 * AW;

endpackage

// File: rtl/reg_seq_alu.sv
// Combinational ALU: result, carry/borrow, zero flag and a write-enable that is
// low only for NOP.
module reg_seq_alu
    import reg_seq_pkg::*;
(
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] res,
    output logic          c,
    output logic          z,
    output logic          we
);

    logic [DW:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        res = '0;
        c   = 1'b0;
        we  = 1'b1;
        case (op)
            OP_NOP: we = 1'b0;
            OP_MOV: res = a;
            OP_ADD: begin
                res = sum[DW-1:0];
                c   = sum[DW];
            end
            OP_SUB: begin
                res = a - b;
                c   = (a < b);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_LDI: res = imm;
            default: we = 1'b0;
        endcase
    end

    assign z = (res == '0);

endmodule

// File: rtl/reg_seq_ctrl.sv
// Four-state micro-sequencer that reads two REG operands, runs them through the
// ALU and writes the result back with a one-cycle EN pulse.
module reg_seq_ctrl
    import reg_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] instr,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          flag_z,
    output logic          flag_c,
    output logic          rf_en,
    output logic [AW-1:0] rf_dir_a,
    output logic [AW-1:0] rf_dir_b,
    output logic [AW-1:0] rf_dir_wr,
    output logic [DW-1:0] rf_di,
    input  logic [DW-1:0] rf_doa,
    input  logic [DW-1:0] rf_dob
);

    state_e        state_q;
    logic [IW-1:0] instr_q;
    logic [DW-1:0] result_q;
    logic          flag_z_q;
    logic          flag_c_q;
    logic          done_q;
    logic          rf_en_q;

    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_z;
    logic          alu_we;

    reg_seq_alu u_alu (
        .op  (instr_q[OP_LSB +: 3]),
        .a   (rf_doa),
        .b   (rf_dob),
        .imm (instr_q[IMM_LSB +: DW]),
        .res (alu_res),
        .c   (alu_c),
        .z   (alu_z),
        .we  (alu_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            done_q   <= 1'b0;
            rf_en_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading pre-edge values of the others.
            done_q  <= 1'b0;
            rf_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        instr_q <= instr;
                        state_q <= S_READ;
                    end
                end
                S_READ: state_q <= S_EXEC;
                S_EXEC: begin
                    // REG data captured at the end of READ is valid here.
                    if (alu_we) begin
                        result_q <= alu_res;
                        flag_z_q <= alu_z;
                        flag_c_q <= alu_c;
                    end
                    rf_en_q <= alu_we;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign rf_en     = rf_en_q;
    assign rf_dir_a  = instr_q[RA_LSB +: AW];
    assign rf_dir_b  = instr_q[RB_LSB +: AW];
    assign rf_dir_wr = instr_q[RD_LSB +: AW];
    assign rf_di     = result_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl: a behavioural REG sits behind the controller and an
// arithmetic reference model predicts every result, flag and write.
module tb_reg_seq_ctrl;
    import reg_seq_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] instr;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          flag_z;
    logic          flag_c;
    logic          rf_en;
    logic [AW-1:0] rf_dir_a;
    logic [AW-1:0] rf_dir_b;
    logic [AW-1:0] rf_dir_wr;
    logic [DW-1:0] rf_di;
    logic [DW-1:0] rf_doa;
    logic [DW-1:0] rf_dob;

    reg_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .rf_en     (rf_en),
        .rf_dir_a  (rf_dir_a),
        .rf_dir_b  (rf_dir_b),
        .rf_dir_wr (rf_dir_wr),
        .rf_di     (rf_di),
        .rf_doa    (rf_doa),
        .rf_dob    (rf_dob)
    );

    always #5 clk = ~clk;

    // Behavioural REG: write when EN=1, registered dual read when EN=0, no reset.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (rf_en) mem[rf_dir_wr] <= rf_di;
        else begin
            rf_doa <= mem[rf_dir_a];
            rf_dob <= mem[rf_dir_b];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int ref_rf [4] = '{0, 0, 0, 0};
    int ref_res = 0;
    int ref_z = 0;
    int ref_c = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] ra, input logic [7:0] imm);
        return {op, rd, ra, imm};
    endfunction

    // Offers one instruction, follows it through all four cycles and updates the model.
    task automatic run_instr(input logic [IW-1:0] ins, input bit hold, output int acc_cyc);
        int op, rd, ra, rb, imm, a, b, r, c, waited;
        bit upd;
        waited = 0;
        while (!in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", in_ready, 1);
        in_valid = 1'b1;
        instr    = ins;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
        instr = IW'($urandom);

        op  = int'(ins[14:12]);
        rd  = int'(ins[11:10]);
        ra  = int'(ins[9:8]);
        imm = int'(ins[7:0]);
        rb  = imm % 4;
        a   = ref_rf[ra];
        b   = ref_rf[rb];
        upd = 1'b1;
        r   = 0;
        c   = 0;
        case (op)
            0: upd = 1'b0;
            1: r = a;
            2: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            3: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = imm;
        endcase
        if (upd) begin
            ref_res = r;
            ref_c   = c;
            ref_z   = (r == 0) ? 1 : 0;
        end

        @(negedge clk);
        check("read_busy", busy, 1);
        check("read_ready", in_ready, 0);
        check("read_en", rf_en, 0);
        check("read_dir_a", rf_dir_a, ra);
        check("read_dir_b", rf_dir_b, rb);
        @(negedge clk);
        check("exec_en", rf_en, 0);
        check("exec_done", done, 0);
        @(negedge clk);
        check("write_en", rf_en, upd);
        check("write_dir", rf_dir_wr, rd);
        check("write_di", rf_di, ref_res);
        check("write_done", done, 0);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_en", rf_en, 0);
        check("done_ready", in_ready, 1);
        check("done_busy", busy, 0);
        check("result", result, ref_res);
        check("flag_z", flag_z, ref_z);
        check("flag_c", flag_c, ref_c);
        if (upd) ref_rf[rd] = r;
        check("rf_content", mem[rd], ref_rf[rd]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        logic [DW-1:0] keep_res;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", rf_en, 0);
        check("rst_result", result, 0);
        check("rst_flag_z", flag_z, 0);
        check("rst_flag_c", flag_c, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add.
        run_instr(mk(OP_LDI, 2'd0, 2'd0, 8'h00), 1'b0, a0);
        run_instr(mk(OP_LDI, 2'd1, 2'd0, 8'h05), 1'b0, a0);
        run_instr(mk(OP_LDI, 2'd2, 2'd0, 8'h03), 1'b0, a0);
        run_instr(mk(OP_ADD, 2'd3, 2'd1, 8'h02), 1'b0, a0);
        check("add_result", result, 8'h08);
        check("add_mem_r3", mem[3], 8'h08);

        // Carry, zero and borrow.
        run_instr(mk(OP_LDI, 2'd1, 2'd0, 8'hFF), 1'b0, a0);
        run_instr(mk(OP_LDI, 2'd2, 2'd0, 8'h01), 1'b0, a0);
        run_instr(mk(OP_ADD, 2'd0, 2'd1, 8'h02), 1'b0, a0);
        check("addc_result", result, 8'h00);
        check("addc_c", flag_c, 1);
        check("addc_z", flag_z, 1);
        run_instr(mk(OP_SUB, 2'd0, 2'd2, 8'h01), 1'b0, a0);
        check("sub_result", result, 8'h02);
        check("sub_borrow", flag_c, 1);

        // NOP keeps result and flags.
        keep_res = result;
        run_instr(mk(OP_NOP, 2'd1, 2'd3, 8'h00), 1'b0, a0);
        check("nop_result", result, keep_res);
        check("nop_mem_r1", mem[1], 8'hFF);

        // Back-to-back with in_valid held, XOR right after a write of r3.
        run_instr(mk(OP_LDI, 2'd3, 2'd0, 8'h5A), 1'b1, a0);
        run_instr(mk(OP_XOR, 2'd3, 2'd3, 8'h03), 1'b1, a1);
        check("xor_result", result, 8'h00);
        check("xor_z", flag_z, 1);
        run_instr(mk(OP_OR, 2'd0, 2'd1, 8'h02), 1'b0, a2);
        check("spacing_1", a1 - a0, 4);
        check("spacing_2", a2 - a1, 4);

        // Reset during EXEC aborts the write.
        run_instr(mk(OP_LDI, 2'd1, 2'd0, 8'h21), 1'b0, a0);
        run_instr(mk(OP_LDI, 2'd2, 2'd0, 8'h77), 1'b0, a0);
        in_valid = 1'b1;
        instr    = mk(OP_ADD, 2'd2, 2'd1, 8'h01);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_en", rf_en, 0);
        check("abort_ready", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("abort_en_hold", rf_en, 0);
        end
        rst_n   = 1'b1;
        ref_res = 0;
        ref_z   = 0;
        ref_c   = 0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_no_en", rf_en, 0);
        end
        check("abort_mem_r2", mem[2], 8'h77);
        check("abort_ready_after", in_ready, 1);
        check("abort_result", result, 0);

        // Randomized instruction stream against the model.
        for (int i = 0; i < 40; i++) begin
            run_instr(IW'($urandom), bit'($urandom_range(0, 1)), a0);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) check("final_rf", mem[i], ref_rf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
